wb_burst_slave_ram: RTL
=======================

WB_BURST_SLAVE_RAM -- requirements
Module: wb_burst_slave_ram

Interface
REQ-001 SHALL have parameter Dw, default 32, data width.
REQ-002 SHALL have parameter Aw, default 32, word-address width.
REQ-003 SHALL have parameter SELw, default 4, byte-select width (Dw/8).
REQ-004 SHALL have parameter CTIw, default 3, cycle-type width.
REQ-005 SHALL have parameter BTEw, default 2, burst-type width.
REQ-006 SHALL have parameter TAGw, default 3, tag width (accepted, ignored).
REQ-007 SHALL have parameter MEM_AW, default 10, log2 of memory depth in words (MEM_AW < Aw).
REQ-008 SHALL have ports: clk input 1 clock; reset input 1 synchronous active-high reset.
REQ-009 SHALL have inputs: sa_adr_i Aw, sa_dat_i Dw, sa_sel_i SELw, sa_tag_i TAGw, sa_we_i 1, sa_stb_i 1, sa_cyc_i 1, sa_cti_i CTIw, sa_bte_i BTEw.
REQ-010 SHALL have outputs: sa_dat_o Dw, sa_ack_o 1, sa_err_o 1, sa_rty_o 1, trigger 1 (DfD), trace 32 (DfD).

Function
REQ-011 SHALL hold 2**MEM_AW words of Dw bits, synchronous read, byte-lane writes per sa_sel_i.
REQ-012 SHALL decode in-range as sa_adr_i[Aw-1:MEM_AW]==0; index = sa_adr_i[MEM_AW-1:0].
REQ-013 SHALL implement FSM states IDLE, CLASSIC, BURST, ERR.
REQ-014 IDLE: cyc&stb and out-of-range -> ERR; cyc&stb and cti==3'b010 -> BURST, counter loaded with index; other cyc&stb -> CLASSIC.
REQ-015 CLASSIC: sa_ack_o=1 for exactly one cycle, sa_dat_o=mem[index]; write occurs on that cycle if we; then IDLE (back-to-back classic accesses take 2 cycles each).
REQ-016 ERR: sa_err_o=1 for one cycle, no write, sa_ack_o=0; then IDLE.
REQ-017 BURST: sa_ack_o = cyc&stb (first ack one cycle after entry); each ack writes (if we) or returns mem[counter], then counter advances.
REQ-018 Counter advance per sa_bte_i: 00 linear (modulo 2**MEM_AW), 01 wrap-4, 10 wrap-8, 11 wrap-16 (upper bits held, low 2/3/4 bits increment modulo).
REQ-019 Read data SHALL be prefetched: RAM read address = next counter on ack cycles, else current counter, giving zero-wait reads every cycle.
REQ-020 BURST stb low with cyc high: ack=0, counter and sa_dat_o held.
REQ-021 BURST ack with cti==3'b111 -> IDLE next cycle.
REQ-022 cyc low in any state -> IDLE next cycle; ack/err SHALL be 0 while cyc low.
REQ-023 sa_rty_o SHALL be constant 0; sa_ack_o and sa_err_o SHALL never both be 1.
REQ-024 trigger SHALL be 1 exactly on cycles sa_err_o=1; trace = {state[1:0], sa_adr_i[29:0]} when trigger, else 0.

Reset
REQ-025 On reset: state IDLE, sa_ack_o=0, sa_err_o=0, trigger=0, trace=0, counter 0; sa_dat_o 0; memory contents untouched.
REQ-026 Reset mid-burst SHALL abort without a write on that cycle; IDLE next cycle.

Configuration
REQ-027 Macro WB_RAM_BURST_EN: defined -> BURST state and REQ-017..021 compiled in; undefined -> BURST removed, all cycles (any cti/bte) handled as CLASSIC.

Verification
REQ-028 Classic write 0xDEADBEEF sel 4'hF to adr 5, then classic read adr 5 -> ack one cycle after each stb, read data 0xDEADBEEF, ack high one cycle only.
REQ-029 Byte write sel 4'b0010 data 0x0000AB00 over 0x11223344 at adr 7 -> read returns 0x1122AB44.
REQ-030 Incrementing burst read, bte=01, start adr 6, 4 beats, last cti=111 -> acks on 4 consecutive cycles, data from adr 6,7,4,5, IDLE afterward.
REQ-031 Access adr 2**MEM_AW -> err one cycle, ack 0, trigger 1, memory unchanged.
REQ-032 Linear burst write stalled by stb low 2 cycles mid-burst, then cyc dropped after beat 3 -> no acks during stall, 3 words written consecutively, next-cycle IDLE.
REQ-033 Build without WB_RAM_BURST_EN, issue cti=010 read -> handled as classic, ack spacing 2 cycles.

Source files
------------

// File: rtl/wb_burst_slave_ram.sv
// Wishbone slave RAM with classic single-beat and optional incrementing-burst access.
// Burst support is compiled in when WB_RAM_BURST_EN is defined; otherwise every cycle is classic.
module wb_burst_slave_ram #(
  parameter int Dw     = 32,
  parameter int Aw     = 32,
  parameter int SELw   = 4,
  parameter int CTIw   = 3,
  parameter int BTEw   = 2,
  parameter int TAGw   = 3,
  parameter int MEM_AW = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Aw-1:0]   sa_adr_i,
  input  logic [Dw-1:0]   sa_dat_i,
  input  logic [SELw-1:0] sa_sel_i,
  input  logic [TAGw-1:0] sa_tag_i,
  input  logic            sa_we_i,
  input  logic            sa_stb_i,
  input  logic            sa_cyc_i,
  input  logic [CTIw-1:0] sa_cti_i,
  input  logic [BTEw-1:0] sa_bte_i,
  output logic [Dw-1:0]   sa_dat_o,
  output logic            sa_ack_o,
  output logic            sa_err_o,
  output logic            sa_rty_o,
  output logic            trigger,
  output logic [31:0]     trace
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLASSIC = 2'd1,
    BURST   = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t            state_q;
  logic [Dw-1:0]     mem [0:(1<<MEM_AW)-1];
  logic [Dw-1:0]     rdata_q;
  logic [MEM_AW-1:0] index;
  logic [MEM_AW-1:0] raddr;
  logic [MEM_AW-1:0] waddr;
  logic              in_range;
  logic              ack;
  logic              err;

  assign in_range = (sa_adr_i[Aw-1:MEM_AW] == '0);
  assign index    = sa_adr_i[MEM_AW-1:0];

  always_comb begin
    ack = 1'b0;
    err = 1'b0;
    if (!reset && sa_cyc_i) begin
      case (state_q)
        CLASSIC: ack = 1'b1;
        ERR:     err = 1'b1;
`ifdef WB_RAM_BURST_EN
        BURST:   ack = sa_stb_i;
`endif
        default: ;
      endcase
    end
  end

`ifdef WB_RAM_BURST_EN
  logic [MEM_AW-1:0] cnt_q;
  logic [MEM_AW-1:0] cnt_d;
  logic              is_burst;
  logic              is_last;
  logic              unused_tag;

  assign is_burst   = (sa_cti_i == CTIw'(3'b010));
  assign is_last    = (sa_cti_i == CTIw'(3'b111));
  assign unused_tag = ^sa_tag_i;

  // Wrapping bursts keep the upper counter bits and roll only the low bits.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    case (sa_bte_i)
      BTEw'(1): cnt_d = {cnt_q[MEM_AW-1:2], cnt_q[1:0] + 2'd1};
      BTEw'(2): cnt_d = {cnt_q[MEM_AW-1:3], cnt_q[2:0] + 3'd1};
      BTEw'(3): cnt_d = {cnt_q[MEM_AW-1:4], cnt_q[3:0] + 4'd1};
      default:  ;
    endcase
  end

  // Prefetch the following word on an ack so back-to-back beats need no wait states.
  always_comb begin
    raddr = index;
    waddr = index;
    if (state_q == BURST) begin
      raddr = ack ? cnt_d : cnt_q;
      waddr = cnt_q;
    end
  end
`else
  logic unused_ctl;

  assign unused_ctl = ^{sa_tag_i, sa_cti_i, sa_bte_i};
  assign raddr      = index;
  assign waddr      = index;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
`ifdef WB_RAM_BURST_EN
      cnt_q   <= '0;
`endif
    end else if (!sa_cyc_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sa_stb_i) begin
            if (!in_range) begin
              state_q <= ERR;
`ifdef WB_RAM_BURST_EN
            end else if (is_burst) begin
              state_q <= BURST;
              cnt_q   <= index;
`endif
            end else begin
              state_q <= CLASSIC;
            end
          end
        end
`ifdef WB_RAM_BURST_EN
        BURST: begin
          if (ack) begin
            cnt_q <= cnt_d;
            if (is_last) state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ack && sa_we_i) begin
      for (int i = 0; i < SELw; i++) begin
        if (sa_sel_i[i]) mem[waddr][i*8 +: 8] <= sa_dat_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem[raddr];
  end

  assign sa_dat_o = rdata_q;
  assign sa_ack_o = ack;
  assign sa_err_o = err;
  assign sa_rty_o = 1'b0;
  assign trigger  = err;
  assign trace    = err ? {state_q, sa_adr_i[29:0]} : 32'h0;

endmodule
